clock_edge_monitor: RTL and testbench

CLOCK_EDGE_MONITOR -- requirements
Module: clock_edge_monitor

---
 rtl/clock_edge_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_clock_edge_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_edge_monitor.sv
// Gated rising-edge counter for two asynchronous clock outputs. Each measurement
// counts edges over a latched window and checks the counts against latched bounds.
module clock_edge_monitor #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window,
  input  logic [1:0]       mon_in,
  input  logic [CNT_W-1:0] exp_min0,
  input  logic [CNT_W-1:0] exp_max0,
  input  logic [CNT_W-1:0] exp_min1,
  input  logic [CNT_W-1:0] exp_max1,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic [1:0]       pass,
  output logic [1:0]       ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  // Returns {overflow_hit, next_count}; the count sticks at CNT_MAX once full.
  function automatic logic [CNT_W:0] sat_step(input logic [CNT_W-1:0] cnt, input logic ev);
    logic [CNT_W:0] res;
    if (!ev) begin
      res = {1'b0, cnt};
    end else if (cnt == CNT_MAX) begin
      res = {1'b1, cnt};
    end else begin
      res = {1'b0, cnt + CNT_ONE};
    end
    return res;
  endfunction

  function automatic logic in_range(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi, input logic ovf_bit);
    return (cnt >= lo) && (cnt <= hi) && !ovf_bit;
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         sync1_q, sync2_q, prev_q;
  logic [WIN_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   work0_q, work0_d, work1_q, work1_d;
  logic [1:0]         wovf_q, wovf_d;
  logic [CNT_W-1:0]   min0_q, min0_d, max0_q, max0_d, min1_q, min1_d, max1_q, max1_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]   count0_q, count0_d, count1_q, count1_d;
  logic [1:0]         pass_q, pass_d, ovf_q, ovf_d;
  logic [1:0]         edge_s;
  logic [CNT_W:0]     step0_s, step1_s;

  assign edge_s  = sync2_q & ~prev_q;
  assign step0_s = sat_step(work0_q, edge_s[0]);
  assign step1_s = sat_step(work1_q, edge_s[1]);

  // Synchronizer and previous-value chain; prev always follows the synced level,
  // so a level already high when ARM loads it never reads as an edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
    end else begin
      sync1_q <= mon_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state, working counters and result capture.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    work0_d  = work0_q;
    work1_d  = work1_q;
    wovf_d   = wovf_q;
    min0_d   = min0_q;
    max0_d   = max0_q;
    min1_d   = min1_q;
    max1_d   = max1_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    count0_d = count0_q;
    count1_d = count1_q;
    pass_d   = pass_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          rem_d   = window;
          min0_d  = exp_min0;
          max0_d  = exp_max0;
          min1_d  = exp_min1;
          max1_d  = exp_max1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        work0_d = CNT_ZERO;
        work1_d = CNT_ZERO;
        wovf_d  = 2'b00;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rem_q == WIN_ZERO) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        work0_d = step0_s[CNT_W-1:0];
        work1_d = step1_s[CNT_W-1:0];
        wovf_d  = wovf_q | {step1_s[CNT_W], step0_s[CNT_W]};
        rem_d   = rem_q - WIN_ONE;
        // Abort wins even on the final window cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rem_q == WIN_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Results are captured on entry to DONE so they appear together with done.
    if (state_d == ST_DONE) begin
      done_d   = 1'b1;
      count0_d = work0_d;
      count1_d = work1_d;
      ovf_d    = wovf_d;
      pass_d   = {in_range(work1_d, min1_q, max1_q, wovf_d[1]),
                  in_range(work0_d, min0_q, max0_q, wovf_d[0])};
    end else begin
      done_d = 1'b0;
    end

    if ((state_d == ST_ARM) || (state_d == ST_COUNT)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State, working and output registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      rem_q    <= WIN_ZERO;
      work0_q  <= CNT_ZERO;
      work1_q  <= CNT_ZERO;
      wovf_q   <= 2'b00;
      min0_q   <= CNT_ZERO;
      max0_q   <= CNT_ZERO;
      min1_q   <= CNT_ZERO;
      max1_q   <= CNT_ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count0_q <= CNT_ZERO;
      count1_q <= CNT_ZERO;
      pass_q   <= 2'b00;
      ovf_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      work0_q  <= work0_d;
      work1_q  <= work1_d;
      wovf_q   <= wovf_d;
      min0_q   <= min0_d;
      max0_q   <= max0_d;
      min1_q   <= min1_d;
      max1_q   <= max1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
      pass_q   <= pass_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign count0 = count0_q;
  assign count1 = count1_q;
  assign pass   = pass_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Bench for clock_edge_monitor: a default-width and a 4-bit-counter instance share
// stimulus; expected results come from counting transitions in a sampled history.
module tb_clock_edge_monitor;

  logic        clock = 1'b0;
  logic        resetb, start, abort;
  logic [15:0] window;
  logic [1:0]  mon_in;
  logic [15:0] min0, max0, min1, max1;
  logic [3:0]  min40, max40, min41, max41;
  logic        busy, done, busy4, done4;
  logic [15:0] c0, c1;
  logic [3:0]  c40, c41;
  logic [1:0]  pass, ovf, pass4, ovf4;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [1:0] hist [0:65535];

  int   mode0, mode1, per0, per1;
  logic hv0, hv1;

  logic [15:0] e_c0, e_c1;
  logic [3:0]  e4_c0, e4_c1;
  logic [1:0]  e_pass, e_ovf, e4_pass, e4_ovf;

  clock_edge_monitor #(.WIN_W(16), .CNT_W(16)) dut (
    .clock(clock), .resetb(resetb), .start(start), .abort(abort), .window(window),
    .mon_in(mon_in), .exp_min0(min0), .exp_max0(max0), .exp_min1(min1), .exp_max1(max1),
    .busy(busy), .done(done), .count0(c0), .count1(c1), .pass(pass), .ovf(ovf));

  clock_edge_monitor #(.WIN_W(16), .CNT_W(4)) dut4 (
    .clock(clock), .resetb(resetb), .start(start), .abort(abort), .window(window),
    .mon_in(mon_in), .exp_min0(min40), .exp_max0(max40), .exp_min1(min41), .exp_max1(max41),
    .busy(busy4), .done(done4), .count0(c40), .count1(c41), .pass(pass4), .ovf(ovf4));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    hist[cyc] <= mon_in;
    cyc       <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic gen_bit(input int mode, input int per, input logic hv, input int c);
    logic b;
    case (mode)
      1:       b = ((c % per) < (per / 2));
      2:       b = 1'($urandom_range(0, 1));
      default: b = hv;
    endcase
    return b;
  endfunction

  task automatic tick();
    @(negedge clock);
    mon_in = {gen_bit(mode1, per1, hv1, cyc), gen_bit(mode0, per0, hv0, cyc)};
  endtask

  // Rising transitions of one channel among the samples taken in the W gate cycles.
  function automatic int raw_edges(input int ch, input int t0, input int w);
    int n = 0;
    for (int j = t0; j < t0 + w; j++) begin
      if (hist[j][ch] && !hist[j-1][ch]) n++;
    end
    return n;
  endfunction

  task automatic model(input int t0, input int w);
    int r0, r1;
    r0 = raw_edges(0, t0, w);
    r1 = raw_edges(1, t0, w);
    e_ovf   = {r1 > 65535, r0 > 65535};
    e_c0    = (r0 > 65535) ? 16'hFFFF : 16'(r0);
    e_c1    = (r1 > 65535) ? 16'hFFFF : 16'(r1);
    e_pass  = {(e_c1 >= min1) && (e_c1 <= max1) && !e_ovf[1],
               (e_c0 >= min0) && (e_c0 <= max0) && !e_ovf[0]};
    e4_ovf  = {r1 > 15, r0 > 15};
    e4_c0   = (r0 > 15) ? 4'hF : 4'(r0);
    e4_c1   = (r1 > 15) ? 4'hF : 4'(r1);
    e4_pass = {(e4_c1 >= min41) && (e4_c1 <= max41) && !e4_ovf[1],
               (e4_c0 >= min40) && (e4_c0 <= max40) && !e4_ovf[0]};
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_count0"}, 32'(c0), 32'(e_c0));
    chk({tag, "_count1"}, 32'(c1), 32'(e_c1));
    chk({tag, "_pass"}, 32'(pass), 32'(e_pass));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    chk({tag, "_count0_w4"}, 32'(c40), 32'(e4_c0));
    chk({tag, "_count1_w4"}, 32'(c41), 32'(e4_c1));
    chk({tag, "_pass_w4"}, 32'(pass4), 32'(e4_pass));
    chk({tag, "_ovf_w4"}, 32'(ovf4), 32'(e4_ovf));
  endtask

  task automatic measure(input int w, input bit poke);
    int t0, k;
    window = 16'(w);
    start  = 1'b1;
    t0     = cyc;
    tick();
    start = 1'b0;
    k = 1;
    chk("busy_in_arm", 32'({busy4, busy}), 32'(2'b11));
    while (done !== 1'b1 && k < w + 20) begin
      if (poke && k == 3) begin
        start  = 1'b1;
        window = 16'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    chk("done_latency", 32'(k), 32'(w + 2));
    chk("done_w4_aligned", 32'(done4), 32'(1));
    model(t0, w);
    check_held("result");
    tick();
    chk("done_single_pulse", 32'({done4, done}), 32'(2'b00));
    chk("busy_after_done", 32'({busy4, busy}), 32'(2'b00));
  endtask

  task automatic abort_run(input int w, input int at);
    int k;
    bit seen;
    window = 16'(w);
    start  = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (k < at) begin
      tick();
      k++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy_low", 32'({busy4, busy}), 32'(2'b00));
    seen = 1'b0;
    repeat (w + 5) begin
      if (done || done4) seen = 1'b1;
      tick();
    end
    chk("abort_no_done", 32'(seen), 32'(0));
    check_held("abort_hold");
  endtask

  initial begin
    bit seen;
    resetb = 1'b0; start = 1'b0; abort = 1'b0; window = 16'd0; mon_in = 2'b00;
    mode0 = 0; mode1 = 0; per0 = 2; per1 = 2; hv0 = 1'b0; hv1 = 1'b0;
    min0 = 16'd0; max0 = 16'd10; min1 = 16'd3; max1 = 16'd10;
    min40 = 4'd0; max40 = 4'd15; min41 = 4'd0; max41 = 4'd15;
    repeat (3) tick();
    chk("reset_outputs", 32'({busy, done, pass, ovf}), 32'(0));
    chk("reset_counts", 32'({c0, c1}), 32'(0));
    chk("reset_outputs_w4", 32'({busy4, done4, pass4, ovf4, c40, c41}), 32'(0));

    // Start on the very first edge after release; empty window, ch1 min above zero.
    resetb = 1'b1;
    measure(0, 1'b0);
    chk("win0_pass", 32'(pass), 32'(2'b01));

    // Nominal clocks: 4-cycle and 12-cycle periods over 1200 cycles.
    mode0 = 1; per0 = 4; mode1 = 1; per1 = 12;
    min0 = 16'd299; max0 = 16'd301; min1 = 16'd99; max1 = 16'd101;
    repeat (6) tick();
    measure(1200, 1'b1);
    chk("nominal_pass", 32'(pass), 32'(2'b11));

    // Fastest legal rate saturates the 4-bit instance.
    mode0 = 1; per0 = 2; mode1 = 0; hv1 = 1'b0;
    repeat (4) tick();
    measure(100, 1'b0);
    chk("sat_count0_w4", 32'(c40), 32'(15));
    chk("sat_ovf0_w4", 32'(ovf4[0]), 32'(1));
    chk("sat_pass0_w4", 32'(pass4[0]), 32'(0));

    // Level held high before start yields no edges.
    mode0 = 0; hv0 = 1'b1;
    repeat (6) tick();
    measure(100, 1'b0);
    chk("held_high_count0", 32'(c0), 32'(0));

    // Aborts: mid-window, in ARM, and on the final window cycle.
    mode0 = 1; per0 = 6; mode1 = 2;
    repeat (4) tick();
    abort_run(1000, 50);
    abort_run(30, 1);
    abort_run(20, 21);
    measure(40, 1'b0);

    // Randomized runs against the history model.
    for (int it = 0; it < 8; it++) begin
      mode0 = $urandom_range(0, 2); per0 = 2 * $urandom_range(1, 8); hv0 = 1'($urandom_range(0, 1));
      mode1 = $urandom_range(0, 2); per1 = 2 * $urandom_range(1, 8); hv1 = 1'($urandom_range(0, 1));
      min0 = 16'($urandom_range(0, 80)); max0 = min0 + 16'($urandom_range(0, 80));
      min1 = 16'($urandom_range(0, 80)); max1 = min1 + 16'($urandom_range(0, 80));
      min40 = 4'($urandom_range(0, 15)); max40 = 4'($urandom_range(0, 15));
      min41 = 4'($urandom_range(0, 15)); max41 = 4'($urandom_range(0, 15));
      repeat (4) tick();
      measure($urandom_range(0, 300), it == 2);
    end

    // Reset in the middle of a window.
    mode0 = 1; per0 = 4; mode1 = 1; per1 = 8;
    window = 16'd500;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    resetb = 1'b0;
    #1;
    chk("midreset_outputs", 32'({busy, done, pass, ovf}), 32'(0));
    chk("midreset_counts", 32'({c0, c1}), 32'(0));
    chk("midreset_outputs_w4", 32'({busy4, done4, pass4, ovf4, c40, c41}), 32'(0));
    e_c0 = 16'd0; e_c1 = 16'd0; e_pass = 2'b00; e_ovf = 2'b00;
    e4_c0 = 4'd0; e4_c1 = 4'd0; e4_pass = 2'b00; e4_ovf = 2'b00;
    repeat (3) tick();
    resetb = 1'b1;
    seen = 1'b0;
    repeat (600) begin
      if (done || done4 || busy || busy4) seen = 1'b1;
      tick();
    end
    chk("midreset_no_done", 32'(seen), 32'(0));
    check_held("post_reset");
    measure(60, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
